// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: register/word types and the pipeline
// controller state encoding.
package cpu_types_pkg;

  localparam int REG_W  = 5;
  localparam int WORD_W = 32;

  typedef logic [REG_W-1:0]  regbits_t;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator: flags an ID-stage instruction that reads the
// destination of a load still in EX. Register 0 never creates a hazard.
module hazard_detect
  import cpu_types_pkg::*;
#(
  parameter int REG_AW = REG_W
) (
  input  logic              ex_dREN,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              load_use
);

  assign load_use = ex_dREN && (ex_rd != '0) &&
                    ((ex_rd == id_rs) || (ex_rd == id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: per-latch enable/flush and PC enable from memory
// handshakes, load-use hazards, redirects and halt.
// Optional performance counters are built when PIPELINE_CTRL_PERF_EN is defined.
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int REG_AW = REG_W,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              mem_dREN,
  input  logic              mem_dWEN,
  input  logic              mem_halt,
  input  logic              mem_redirect,
  input  logic              ex_dREN,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_en,
  output logic              idex_flush,
  output logic              exmem_en,
  output logic              exmem_flush,
  output logic              memwb_en,
`ifdef PIPELINE_CTRL_PERF_EN
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  dwait_cnt,
`endif
  output logic              halt
);

  ctrl_state_t state, next_state;
  logic        load_use;
  logic        mem_req;
  logic        mem_miss;

  assign mem_req  = mem_dREN | mem_dWEN;
  assign mem_miss = mem_req & ~dhit;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .ex_dREN  (ex_dREN),
    .ex_rd    (ex_rd),
    .id_rs    (id_rs),
    .id_rt    (id_rt),
    .load_use (load_use)
  );

  // State register; reset returns to RUN and clears halt immediately.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= RUN;
    else       state <= next_state;
  end

  // Prioritised latch controls and next-state decision.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_en    = 1'b1;
    exmem_flush = 1'b0;
    memwb_en    = 1'b1;
    halt        = 1'b0;
    next_state  = state;

    if (state == HALTED) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      halt       = 1'b1;
      next_state = HALTED;
    end else if (state != RUN && state != DWAIT) begin
      next_state = RUN;
    end else if (mem_halt) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      next_state = HALTED;
    end else if (mem_miss) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      next_state = DWAIT;
    end else begin
      next_state = RUN;
      if (mem_redirect) begin
        ifid_en     = 1'b0;
        ifid_flush  = 1'b1;
        idex_en     = 1'b0;
        idex_flush  = 1'b1;
        exmem_en    = 1'b0;
        exmem_flush = 1'b1;
      end else if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        idex_flush = 1'b1;
      end else if (!ihit) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b1;
      end
    end
  end

`ifdef PIPELINE_CTRL_PERF_EN
  logic active;
  logic stall_ev;
  logic flush_ev;

  assign active   = (state == RUN) || (state == DWAIT);
  assign stall_ev = active && !mem_halt && !mem_miss && !mem_redirect && load_use;
  assign flush_ev = active && !mem_halt && !mem_miss && mem_redirect;

  // Saturating event counters, frozen once halted.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      dwait_cnt <= '0;
    end else if (state != HALTED) begin
      if (stall_ev && stall_cnt != '1)         stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_ev && flush_cnt != '1)         flush_cnt <= flush_cnt + CNT_W'(1);
      if (state == DWAIT && dwait_cnt != '1)   dwait_cnt <= dwait_cnt + CNT_W'(1);
    end
  end
`endif

  // No latch may ever see enable and flush together.
  a_ifid_excl:  assert property (@(posedge CLK) disable iff (!nRST) !(ifid_en && ifid_flush));
  a_idex_excl:  assert property (@(posedge CLK) disable iff (!nRST) !(idex_en && idex_flush));
  a_exmem_excl: assert property (@(posedge CLK) disable iff (!nRST) !(exmem_en && exmem_flush));

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl.
module tb_pipeline_ctrl;
  import cpu_types_pkg::*;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       ihit, dhit, mem_dREN, mem_dWEN, mem_halt, mem_redirect, ex_dREN;
  logic [4:0] ex_rd, id_rs, id_rt;
  logic       pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic       exmem_en, exmem_flush, memwb_en, halt;
`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt, dwait_cnt;
`endif

  int passCount = 0;
  int checkCount = 0;

  // Output vector order: pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
  // exmem_en, exmem_flush, memwb_en, halt
  localparam logic [8:0] ALLEN    = 9'b1_1_0_1_0_1_0_1_0;
  localparam logic [8:0] FREEZE   = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] HALTCYC  = 9'b0_0_0_0_0_0_0_1_0;
  localparam logic [8:0] REDIRECT = 9'b1_0_1_0_1_0_1_1_0;
  localparam logic [8:0] LOADUSE  = 9'b0_0_0_0_1_1_0_1_0;
  localparam logic [8:0] NOIHIT   = 9'b0_0_1_1_0_1_0_1_0;
  localparam logic [8:0] HALTOUT  = 9'b0_0_0_0_0_0_0_0_1;

  pipeline_ctrl dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .ihit         (ihit),
    .dhit         (dhit),
    .mem_dREN     (mem_dREN),
    .mem_dWEN     (mem_dWEN),
    .mem_halt     (mem_halt),
    .mem_redirect (mem_redirect),
    .ex_dREN      (ex_dREN),
    .ex_rd        (ex_rd),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .ifid_flush   (ifid_flush),
    .idex_en      (idex_en),
    .idex_flush   (idex_flush),
    .exmem_en     (exmem_en),
    .exmem_flush  (exmem_flush),
    .memwb_en     (memwb_en),
`ifdef PIPELINE_CTRL_PERF_EN
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
    .dwait_cnt    (dwait_cnt),
`endif
    .halt         (halt)
  );

  // Free-running clock.
  always #5 CLK = ~CLK;

  // Drive one cycle's worth of inputs.
  task automatic applyStimulus(input logic i_ihit, input logic i_dhit,
                               input logic i_dren, input logic i_dwen,
                               input logic i_halt, input logic i_redir,
                               input logic i_exdren, input logic [4:0] i_exrd,
                               input logic [4:0] i_rs, input logic [4:0] i_rt);
    ihit = i_ihit; dhit = i_dhit; mem_dREN = i_dren; mem_dWEN = i_dwen;
    mem_halt = i_halt; mem_redirect = i_redir; ex_dREN = i_exdren;
    ex_rd = i_exrd; id_rs = i_rs; id_rt = i_rt;
  endtask

  // Compare the packed output vector against its expected value.
  task automatic checkOutput(input string tag, input logic [8:0] expected);
    logic [8:0] observed;
    observed = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                exmem_en, exmem_flush, memwb_en, halt};
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
  endtask

  // Compare the controller state against its expected value.
  task automatic checkState(input string tag, input ctrl_state_t expected);
    logic [1:0] observed;
    observed = dut.state;
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
  endtask

`ifdef PIPELINE_CTRL_PERF_EN
  // Compare a performance counter value.
  task automatic checkCount32(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
  endtask
`endif

  // Advance to the next negedge, where the following vector is applied.
  task automatic nextCycle();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Directed sequence.
  initial begin
    nRST = 1'b0;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    #1;
    checkOutput("reset_allen", ALLEN);
    checkState("reset_state", RUN);
`ifdef PIPELINE_CTRL_PERF_EN
    checkCount32("reset_stall_cnt", stall_cnt, 32'd0);
    checkCount32("reset_flush_cnt", flush_cnt, 32'd0);
    checkCount32("reset_dwait_cnt", dwait_cnt, 32'd0);
`endif
    nextCycle();

    // Load-use via rs.
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 5'd8, 5'd8, 5'd3);
    #1 checkOutput("loaduse_rs", LOADUSE);
    nextCycle();
`ifdef PIPELINE_CTRL_PERF_EN
    checkCount32("stall_cnt_1", stall_cnt, 32'd1);
`endif

    // Load-use via rt.
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 5'd9, 5'd4, 5'd9);
    #1 checkOutput("loaduse_rt", LOADUSE);
    nextCycle();

    // Register zero never stalls.
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
    #1 checkOutput("loaduse_r0", ALLEN);
    nextCycle();

    // Matching registers but no load in EX.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 5'd8, 5'd8, 5'd8);
    #1 checkOutput("no_load_match", ALLEN);
    nextCycle();

    // Instruction fetch not complete.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 5'd1, 5'd2, 5'd3);
    #1 checkOutput("no_ihit", NOIHIT);
    nextCycle();

    // Data miss for three cycles, with a lower-priority load-use present.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 1, 0, 0, 0, 1, 5'd8, 5'd8, 5'd0);
      #1 checkOutput($sformatf("dmiss_freeze_%0d", i), FREEZE);
      nextCycle();
      checkState($sformatf("dmiss_state_%0d", i), DWAIT);
    end
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    #1 checkOutput("dhit_release", ALLEN);
    nextCycle();
    checkState("dhit_back_run", RUN);
`ifdef PIPELINE_CTRL_PERF_EN
    checkCount32("dwait_cnt_3", dwait_cnt, 32'd3);
    checkCount32("stall_cnt_frozen_dmiss", stall_cnt, 32'd2);
`endif

    // Store hitting immediately: no stall.
    applyStimulus(1, 1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    #1 checkOutput("store_hit", ALLEN);
    nextCycle();
    checkState("store_hit_run", RUN);

    // Redirect beats load-use and missing ihit.
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 5'd8, 5'd8, 5'd0);
    #1 checkOutput("redirect_wins", REDIRECT);
    nextCycle();
`ifdef PIPELINE_CTRL_PERF_EN
    checkCount32("flush_cnt_1", flush_cnt, 32'd1);
    checkCount32("stall_cnt_unchanged", stall_cnt, 32'd2);
`endif

    // Data miss beats redirect.
    applyStimulus(1, 0, 0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    #1 checkOutput("miss_beats_redirect", FREEZE);
    nextCycle();
    checkState("miss_redirect_dwait", DWAIT);
    applyStimulus(1, 1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    #1 checkOutput("dwait_release", ALLEN);
    nextCycle();

    // Halt beats a data miss; then absorbing.
    applyStimulus(1, 0, 1, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0);
    #1 checkOutput("halt_cycle", HALTCYC);
    nextCycle();
    checkState("halted_state", HALTED);
    applyStimulus(1, 1, 0, 0, 0, 1, 1, 5'd8, 5'd8, 5'd8);
    #1 checkOutput("halted_out_a", HALTOUT);
    nextCycle();
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    #1 checkOutput("halted_out_b", HALTOUT);
    nextCycle();
    checkState("halted_stays", HALTED);
`ifdef PIPELINE_CTRL_PERF_EN
    checkCount32("flush_cnt_frozen", flush_cnt, 32'd1);
`endif

    // Asynchronous reset mid-halt, away from any clock edge.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    #2 nRST = 1'b0;
    #1;
    checkOutput("async_reset_clear", ALLEN);
    checkState("async_reset_run", RUN);
    @(negedge CLK);
    nRST = 1'b1;
    nextCycle();
    checkOutput("post_reset_allen", ALLEN);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
